mem_access: RTL

- Memory-access stage directly downstream of execute.
- Consumes the execute stage's valid/stall handshake, result (ALU value or load/store address), store data, write-enable and writeback register fields.
- Issues load/store requests to the data memory over a req/ack interface and presents the final result to writeback.
- Non-memory ops pass through in one cycle; memory ops hold the pipeline until the memory acks.

---
 rtl/mem_access_pkg.sv | 14 +
 rtl/mem_access.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants and state encoding for the memory-access stage.
// Widths match the surrounding pipeline's parameter set.
package mem_access_pkg;

   localparam int ADDR  = 32;
   localparam int W_OPR = 32;
   localparam int W_RD  = 5;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } ma_state_t;

endpackage

// File: rtl/mem_access.sv
// Memory-access stage: passes ALU ops through, issues ld/st over req/ack.
// Latency: 1 cycle for non-memory ops, >=2 cycles (accept to v_o) for memory ops.
// Backpressure: stall_o while a request is outstanding or the output register is held by stall_i.
module mem_access
   import mem_access_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             v_i,
   output logic             stall_o,
   input  logic [ADDR-1:0]  pc_i,
   input  logic [W_OPR-1:0] result_i,
   input  logic             mem_read_i,
   input  logic             mem_write_i,
   input  logic [W_OPR-1:0] mem_data_i,
   input  logic [W_RD-1:0]  wb_r_i,
   input  logic             wb_i,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   output logic [W_OPR-1:0] dmem_addr_o,
   output logic [W_OPR-1:0] dmem_wdata_o,
   input  logic             dmem_ack_i,
   input  logic [W_OPR-1:0] dmem_rdata_i,
   input  logic             stall_i,
   output logic             v_o,
   output logic [ADDR-1:0]  pc_o,
   output logic [W_OPR-1:0] result_o,
   output logic [W_RD-1:0]  wb_r_o,
   output logic             wb_o
);

   ma_state_t        state_q;
   ma_state_t        state_d;
   logic [ADDR-1:0]  req_pc;
   logic [W_RD-1:0]  req_wb_r;
   logic             req_wb;
   logic             busy;
   logic             accept;
   logic             is_mem;
   logic             ack_fire;

   assign busy     = v_o && stall_i;
   assign is_mem   = mem_read_i || mem_write_i;
   assign accept   = v_i && !stall_o;
   assign ack_fire = dmem_req_o && dmem_ack_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The request is withheld while the output register is held, so an ack
   // can never land with nowhere to put the result.
   always_comb begin
      state_d    = state_q;
      stall_o    = busy;
      dmem_req_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && is_mem) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            stall_o    = 1'b1;
            dmem_req_o = !busy;
            if (dmem_req_o && dmem_ack_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_wdata_o <= '0;
         req_pc       <= '0;
         req_wb_r     <= '0;
         req_wb       <= 1'b0;
      end else if (accept && is_mem) begin
         // Both read and write set is illegal; mem_write_i wins so it acts as a store.
         dmem_we_o    <= mem_write_i;
         dmem_addr_o  <= result_i;
         dmem_wdata_o <= mem_data_i;
         req_pc       <= pc_i;
         req_wb_r     <= wb_r_i;
         req_wb       <= wb_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_o      <= 1'b0;
         pc_o     <= '0;
         result_o <= '0;
         wb_r_o   <= '0;
         wb_o     <= 1'b0;
      end else if (!busy) begin
         if (accept && !is_mem) begin
            v_o      <= 1'b1;
            pc_o     <= pc_i;
            result_o <= result_i;
            wb_r_o   <= wb_r_i;
            wb_o     <= wb_i;
         end else if (ack_fire) begin
            v_o      <= 1'b1;
            pc_o     <= req_pc;
            result_o <= dmem_we_o ? dmem_addr_o : dmem_rdata_i;
            wb_r_o   <= req_wb_r;
            wb_o     <= dmem_we_o ? 1'b0 : req_wb;
         end else begin
            v_o <= 1'b0;
         end
      end
   end

endmodule
